// File: rtl/lsu_bus_if.sv
// ---------------------------------------------------------------------------
// | lsu_bus_if : core data-port and word-bus signal bundle for the LSU       |
// | Revision   : 1.0                                                         |
// ---------------------------------------------------------------------------
`default_nettype none

interface lsu_bus_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic        core_stall_o;
    logic [31:0] core_rd_o;
    logic        bus_err_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_stall_o, core_rd_o, bus_err_o, misalign_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport slave (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_stall_o, core_rd_o, bus_err_o, misalign_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

`default_nettype wire

// File: rtl/lsu_bus_adapter.sv
// ---------------------------------------------------------------------------
// | lsu_bus_adapter : core load/store port to word bus, with bus timeout     |
// | Optional macro LSU_MISALIGN_CHECK_EN aborts misaligned H/W accesses.     |
// | Revision        : 1.0                                                    |
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_bus_adapter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    lsu_bus_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] KIND_BYTE = 2'd0;
    localparam logic [1:0] KIND_HALF = 2'd1;
    localparam logic [1:0] KIND_WORD = 2'd2;
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        acc_we;
    logic [2:0]  acc_size;
    logic [1:0]  acc_lo;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] core_rd;
    logic        bus_err;
    logic        misalign;

    logic [1:0]  req_kind;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        misaligned;
    logic [1:0]  acc_kind;
    logic        acc_unsigned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    // Sizes 3/6/7 fall through to word.
    function automatic logic [1:0] size_kind(input logic [2:0] size);
        case (size)
            3'd0, 3'd4: size_kind = KIND_BYTE;
            3'd1, 3'd5: size_kind = KIND_HALF;
            default:    size_kind = KIND_WORD;
        endcase
    endfunction

    always_comb begin
        req_kind = size_kind(bus.core_size_i);
        req_be   = 4'b1111;
        req_wd   = bus.core_wd_i;
        case (req_kind)
            KIND_BYTE: begin
                req_be = 4'b0001 << bus.core_addr_i[1:0];
                req_wd = {4{bus.core_wd_i[7:0]}};
            end
            KIND_HALF: begin
                req_be = 4'b0011 << {bus.core_addr_i[1], 1'b0};
                req_wd = {2{bus.core_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((req_kind == KIND_HALF) && bus.core_addr_i[0]) ||
                        ((req_kind == KIND_WORD) && (bus.core_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane select uses the size/offset captured at request time, not the live core inputs.
    always_comb begin
        acc_kind     = size_kind(acc_size);
        acc_unsigned = acc_size[2];
        rd_byte      = bus.mem_rd_i[{acc_lo, 3'b000} +: 8];
        rd_half      = bus.mem_rd_i[{acc_lo[1], 4'b0000} +: 16];
        load_data    = bus.mem_rd_i;
        case (acc_kind)
            KIND_BYTE: load_data = acc_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            KIND_HALF: load_data = acc_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default:   ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.core_req_i) begin
                    state_next = misaligned ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready_i || (cnt == CNT_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt      <= 8'd0;
            acc_we   <= 1'b0;
            acc_size <= 3'd0;
            acc_lo   <= 2'd0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 4'd0;
            mem_addr <= 32'd0;
            mem_wd   <= 32'd0;
            core_rd  <= 32'd0;
            bus_err  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.core_req_i) begin
                        cnt      <= 8'd0;
                        acc_we   <= bus.core_we_i;
                        acc_size <= bus.core_size_i;
                        acc_lo   <= bus.core_addr_i[1:0];
                        if (misaligned) begin
                            misalign <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= bus.core_we_i;
                            mem_be   <= req_be;
                            mem_addr <= {bus.core_addr_i[31:2], 2'b00};
                            mem_wd   <= req_wd;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ready_i) begin
                        mem_req <= 1'b0;
                        if (!acc_we) begin
                            core_rd <= load_data;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        core_rd <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.core_stall_o = bus.core_req_i & (state != ST_DONE);
    assign bus.core_rd_o    = core_rd;
    assign bus.bus_err_o    = bus_err;
    assign bus.misalign_o   = misalign;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_be_o     = mem_be;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_wd_o     = mem_wd;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_adapter.sv
// ---------------------------------------------------------------------------
// | tb_lsu_bus_adapter : randomized scoreboard bench for lsu_bus_adapter     |
// | Revision           : 1.0                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_bus_adapter;

    localparam int TO    = 4;
    localparam int NEVER = 1000;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mis;
        int          stall;
    } done_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_bus_if bus ();

    lsu_bus_adapter #(.TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_rd    = 32'd0;
    int          resp_delay  = 0;
    logic [31:0] resp_data   = 32'd0;
    bit          auto_resp   = 1'b0;
    bit          mon_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int kind_of(input logic [2:0] size);
        if (size == 3'd0 || size == 3'd4) return 0;
        if (size == 3'd1 || size == 3'd5) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] size,
                                               input logic [1:0] lo);
        int unsigned b = (w >> (8 * int'(lo))) & 32'hFF;
        int unsigned h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        bit uns = (size == 3'd4) || (size == 3'd5);
        case (kind_of(size))
            0:       return (uns || b < 128)   ? b : b + 32'hFFFFFF00;
            1:       return (uns || h < 32768) ? h : h + 32'hFFFF0000;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] lo);
        case (kind_of(size))
            0:       return 4'(1 << int'(lo));
            1:       return 4'(3 << (int'(lo) & 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
        case (kind_of(size))
            0:       return (wd & 32'hFF) * 32'h01010101;
            1:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // ---------------- bus responder ----------------
    initial begin
        int busy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_resp) begin
                if (bus.mem_req_o) busy++;
                else busy = 0;
                bus.mem_ready_i = (busy == resp_delay + 1);
                bus.mem_rd_i    = bus.mem_ready_i ? resp_data : $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int        stall_cnt = 0;
        logic      prev_req  = 1'b0;
        bus_exp_t  cur;
        done_exp_t d;
        cur = '{we: 1'b0, be: 4'd0, addr: 32'd0, wd: 32'd0};
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                prev_req  = 1'b0;
                stall_cnt = 0;
            end else begin
                if (bus.mem_req_o && !prev_req) begin
                    if (bus_q.size() == 0) check("unexpected_mem_req", 32'd1, 32'd0);
                    else cur = bus_q.pop_front();
                end
                if (bus.mem_req_o) begin
                    check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, cur.we});
                    check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, cur.be});
                    check("mem_addr", bus.mem_addr_o, cur.addr);
                    if (cur.we) check("mem_wd", bus.mem_wd_o, cur.wd);
                end
                prev_req = bus.mem_req_o;
                if (bus.core_req_i && bus.core_stall_o) stall_cnt++;
                if (bus.core_req_i && !bus.core_stall_o) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        check("core_rd", bus.core_rd_o, d.rd);
                        check("bus_err", {31'd0, bus.bus_err_o}, {31'd0, d.err});
                        check("misalign", {31'd0, bus.misalign_o}, {31'd0, d.mis});
                        check("stall_cycles", stall_cnt, d.stall);
                    end
                    stall_cnt = 0;
                end else begin
                    check("err_pulse_idle", {30'd0, bus.bus_err_o, bus.misalign_o}, 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input int delay, input logic [31:0] rdata);
        logic [1:0] lo = addr[1:0];
        int         k  = kind_of(size);
        bit         mis = 1'b0;
        bit         done = 1'b0;
        done_exp_t  d;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (k == 1 && lo[0]) || (k == 2 && lo != 2'b00);
`endif
        if (!mis) bus_q.push_back('{we: we, be: model_be(size, lo), addr: addr & 32'hFFFFFFFC,
                                    wd: model_wd(size, wd)});
        if (mis) begin
            d = '{rd: model_rd, err: 1'b0, mis: 1'b1, stall: 1};
        end else if (delay < TO) begin
            if (!we) model_rd = model_load(rdata, size, lo);
            d = '{rd: model_rd, err: 1'b0, mis: 1'b0, stall: 2 + delay};
        end else begin
            model_rd = 32'd0;
            d = '{rd: 32'd0, err: 1'b1, mis: 1'b0, stall: TO + 1};
        end
        done_q.push_back(d);
        resp_delay       = delay;
        resp_data        = rdata;
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = we;
        bus.core_size_i  = size;
        bus.core_addr_i  = addr;
        bus.core_wd_i    = wd;
        for (int i = 0; i < TO + 20 && !done; i++) begin
            @(negedge clk);
            done = !bus.core_stall_o;
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.core_req_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = 32'd0;
        bus.core_wd_i   = 32'd0;
        bus.mem_rd_i    = 32'd0;
        bus.mem_ready_i = 1'b0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
        check("rst_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("rst_mem_wd", bus.mem_wd_o, 32'd0);
        check("rst_core_rd", bus.core_rd_o, 32'd0);
        check("rst_stall", {31'd0, bus.core_stall_o}, 32'd0);
        check("rst_flags", {30'd0, bus.bus_err_o, bus.misalign_o}, 32'd0);

        // Reset in the middle of a bus access, then a stray ready while idle.
        @(posedge clk);
        #1;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h100;
        idle(2);
        check("pre_rst_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        rst_n          = 1'b0;
        bus.core_req_i = 1'b0;
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'hFFFFFFFF;
        idle(1);
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        check("late_ready_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("late_ready_stall", {31'd0, bus.core_stall_o}, 32'd0);
        check("late_ready_core_rd", bus.core_rd_o, 32'd0);

        @(posedge clk);
        #1;
        auto_resp = 1'b1;
        mon_en    = 1'b1;

        // Directed scenarios.
        do_access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 32'd0);
        do_access(1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 32'd0);
        do_access(1'b0, 3'd0, 32'h102, 32'd0, 0, 32'h0080FF00);
        do_access(1'b0, 3'd5, 32'h102, 32'd0, 0, 32'h0080FF00);
        do_access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 1, 32'd0);
        do_access(1'b0, 3'd2, 32'h200, 32'd0, NEVER, 32'h11111111);
        do_access(1'b0, 3'd1, 32'h302, 32'd0, TO - 1, 32'h8001_7FFF);
        do_access(1'b0, 3'd2, 32'h102, 32'd0, 0, 32'hCAFEF00D);
        idle(1);

        for (int n = 0; n < 200; n++) begin
            logic        we    = 1'($urandom_range(0, 1));
            logic [2:0]  size  = 3'($urandom_range(0, 7));
            logic [31:0] addr  = $urandom;
            logic [31:0] wd    = $urandom;
            logic [31:0] rdata = $urandom;
            int          delay;
            if (!we && $urandom_range(0, 5) == 0) delay = NEVER;
            else delay = $urandom_range(0, TO - 1);
            do_access(we, size, addr, wd, delay, rdata);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
